fp_unit_seq: RTL and testbench
==============================

// Module: fp_unit_seq
// PURPOSE
//  Issue/complete sequencer for the combinational FP_Unit datapath.
//  - Accepts one FP operation per valid/ready handshake and latches the operands and control fields.
//  - Drives the latched values to FP_Unit for a per-op number of cycles (multicycle path).
//  - Captures out_data into a result register and presents it on a valid/ready result port.
//  - Sits between the core's FP issue stage and FP_Unit; FP_Unit is instantiated outside.
// PARAMETERS
//  DATA_WIDTH  64  operand/result width
//  LAT_ADDSUB  2   EXEC cycles, op 4'b0000
//  LAT_MUL     3   EXEC cycles, op 4'b0001
//  LAT_DIV     8   EXEC cycles, op 4'b0010
//  LAT_MISC    1   EXEC cycles, ops 4'b0011..4'b0111
//  All LAT_* must be in 1..15; a value outside this range is a compile-time error.
// PORTS
//  in_clk         in   1   clock, rising edge
//  in_rst_n       in   1   asynchronous active-low reset
//  in_valid       in   1   request valid
//  out_ready      out  1   sequencer can accept a request
//  in_rs1/in_rs2  in   DW  operands
//  in_FPU_Op      in   4   op select
//  in_fmt, in_output_fmt, in_addsub_ctrl  in  1 each  FP_Unit controls
//  in_ctrl_minmax_sgnj_cmp  in  3  FP_Unit sub-op
//  in_abort       in   1   synchronous cancel of the op in flight
//  out_fpu_rs1/out_fpu_rs2  out  DW  latched operands to FP_Unit
//  out_fpu_op     out  4   latched op
//  out_fpu_fmt, out_fpu_output_fmt, out_fpu_addsub  out  1 each  latched controls
//  out_fpu_ctrl   out  3   latched sub-op
//  in_fpu_result  in   DW  FP_Unit out_data
//  out_res_valid  out  1   result valid
//  in_res_ready   in   1   consumer takes result
//  out_result     out  DW  registered result
//  out_illegal    out  1   qualifies out_result: op was >= 4'b1000
// BEHAVIOUR
//  States:
//  - IDLE: out_ready=1.
//  - EXEC: counter running.
//  - DONE: out_res_valid=1.
//  Reset (async, in_rst_n=0):
//  - State goes to IDLE; counter and all latched/result registers clear to 0.
//  - Outputs: out_ready=1, out_res_valid=0, out_illegal=0.
//  - Reset mid-op discards the op; no result is produced.
//  IDLE & in_valid:
//  - Accept: latch all request fields into the out_fpu_* registers.
//  - Legal op: go to EXEC with cnt <= LAT_op-1.
//  - Op >= 8: go straight to DONE with out_result=0 and out_illegal=1.
//  EXEC:
//  - cnt!=0: cnt <= cnt-1.
//  - cnt==0: out_result <= in_fpu_result, out_illegal <= 0, go to DONE.
//  - Latency: out_res_valid rises exactly LAT_op clock edges after the accept edge.
//  - in_abort in EXEC: go to IDLE next edge; no result, out_result unchanged.
//  - in_abort has priority over the cnt==0 capture.
//  - in_abort in IDLE or DONE is ignored.
//  DONE:
//  - Hold out_result and out_illegal stable until in_res_ready=1.
//  - in_res_ready=1: go to IDLE; out_res_valid deasserts next cycle.
//  - out_ready=0 (unless FP_SEQ_B2B_EN).
//  Datapath hold:
//  - out_fpu_* are stable from the accept edge until the next accept.
//  - FP_Unit inputs therefore never change during EXEC.
//  - No arithmetic beyond the 4-bit down-counter; no wrap-around possible.
// CONFIGURATION
//  FP_SEQ_B2B_EN undefined:
//  - One op per IDLE->EXEC->DONE->IDLE round trip.
//  - Minimum issue interval is LAT_op+2 cycles.
//  FP_SEQ_B2B_EN defined:
//  - In DONE, out_ready = in_res_ready.
//  - in_res_ready & in_valid in the same cycle retires the result and accepts the new op.
//  - The new op goes directly to EXEC/DONE; the IDLE bubble is removed.
//  - Result and new-op latch update on the same edge.
// TESTING
//  1. Reset mid-EXEC:
//     - Stimulus: op=0001 accepted, then in_rst_n=0 on cycle 2.
//     - Response: out_res_valid=0, out_ready=1 immediately; no result after release.
//  2. DIV latency:
//     - Stimulus: op=0010, in_fpu_result=64'h4000_0000_0000_0000.
//     - Response: out_res_valid rises 8 edges after accept; out_result=64'h4000_0000_0000_0000.
//  3. Backpressure:
//     - Stimulus: in_res_ready=0 for 5 cycles after DONE while in_fpu_result toggles.
//     - Response: out_result stays constant and out_ready=0 throughout.
//  4. Illegal op:
//     - Stimulus: op=4'b1010.
//     - Response: out_res_valid=1 one edge after accept, out_result=0, out_illegal=1.
//  5. Abort:
//     - Stimulus: op=0000, in_abort=1 on the cnt==0 cycle.
//     - Response: next state IDLE, out_res_valid never rises.
//  6. B2B (FP_SEQ_B2B_EN):
//     - Stimulus: in_valid held with in_res_ready=1, op=0011.
//     - Response: one accept every 2 cycles; without the macro, every 3 cycles.

Source files
------------

// File: rtl/fp_unit_seq_if.sv
// Request/result bundle between the FP issue stage, the sequencer and FP_Unit.
// The slave modport is the sequencer's view, and master is the issue stage's view.
// Request side:  in_valid/out_ready, operands, op select, FP_Unit controls, in_abort.
// FP_Unit side:  latched out_fpu_* fields out, in_fpu_result back.
// Result side:   out_res_valid/in_res_ready, out_result, out_illegal.
interface fp_unit_seq_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] in_rs1;
  logic [DATA_WIDTH-1:0] in_rs2;
  logic [3:0]            in_FPU_Op;
  logic                  in_fmt;
  logic                  in_output_fmt;
  logic                  in_addsub_ctrl;
  logic [2:0]            in_ctrl_minmax_sgnj_cmp;
  logic                  in_abort;
  logic [DATA_WIDTH-1:0] out_fpu_rs1;
  logic [DATA_WIDTH-1:0] out_fpu_rs2;
  logic [3:0]            out_fpu_op;
  logic                  out_fpu_fmt;
  logic                  out_fpu_output_fmt;
  logic                  out_fpu_addsub;
  logic [2:0]            out_fpu_ctrl;
  logic [DATA_WIDTH-1:0] in_fpu_result;
  logic                  out_res_valid;
  logic                  in_res_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  out_illegal;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_FPU_Op, in_fmt, in_output_fmt,
           in_addsub_ctrl, in_ctrl_minmax_sgnj_cmp, in_abort, in_fpu_result,
           in_res_ready,
    output out_ready, out_fpu_rs1, out_fpu_rs2, out_fpu_op, out_fpu_fmt,
           out_fpu_output_fmt, out_fpu_addsub, out_fpu_ctrl, out_res_valid,
           out_result, out_illegal
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_FPU_Op, in_fmt, in_output_fmt,
           in_addsub_ctrl, in_ctrl_minmax_sgnj_cmp, in_abort, in_fpu_result,
           in_res_ready,
    input  out_ready, out_fpu_rs1, out_fpu_rs2, out_fpu_op, out_fpu_fmt,
           out_fpu_output_fmt, out_fpu_addsub, out_fpu_ctrl, out_res_valid,
           out_result, out_illegal
  );
endinterface

// File: rtl/fp_unit_seq.sv
// fp_unit_seq: issue/complete sequencer for the combinational FP_Unit datapath.
// The sequencer latches one request per handshake. It holds the latched fields on FP_Unit
// for a number of cycles that depends on the op. It then captures FP_Unit's result
// into a register that is presented on a valid/ready port.
// Ports:
//   in_clk    clock, rising edge
//   in_rst_n  asynchronous active-low reset
//   bus       fp_unit_seq_if.slave (request, FP_Unit drive/return, result)
// Optional feature: define FP_SEQ_B2B_EN to let DONE retire a result and accept
// the next request on the same edge, which removes the IDLE bubble.
module fp_unit_seq #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LAT_ADDSUB = 2,
  parameter int unsigned LAT_MUL    = 3,
  parameter int unsigned LAT_DIV    = 8,
  parameter int unsigned LAT_MISC   = 1
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  fp_unit_seq_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  // Latencies must fit the 4-bit down-counter and be at least one cycle
  if (LAT_ADDSUB < 1 || LAT_ADDSUB > 15 || LAT_MUL < 1 || LAT_MUL > 15 ||
      LAT_DIV < 1 || LAT_DIV > 15 || LAT_MISC < 1 || LAT_MISC > 15) begin : g_lat_range_bad
    $error("fp_unit_seq: every LAT_* parameter must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, result_q, result_d;
  logic [3:0]            op_q, op_d;
  logic                  fmt_q, fmt_d, ofmt_q, ofmt_d, addsub_q, addsub_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic                  illegal_q, illegal_d;
  logic                  accept;
  logic                  op_legal;
  logic                  capture;

  // Initial counter value (latency minus one) for a legal op
  function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
    case (op)
      4'b0000: return CNT_W'(LAT_ADDSUB - 1);
      4'b0001: return CNT_W'(LAT_MUL - 1);
      4'b0010: return CNT_W'(LAT_DIV - 1);
      default: return CNT_W'(LAT_MISC - 1);
    endcase
  endfunction

  assign op_legal = ~bus.in_FPU_Op[3];

  // State register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. An abort outranks the final-cycle capture.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) accept = 1'b1;
      end
      S_EXEC: begin
        if (bus.in_abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          capture = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.in_res_ready) begin
          state_d = S_IDLE;
`ifdef FP_SEQ_B2B_EN
          if (bus.in_valid) accept = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) state_d = op_legal ? S_EXEC : S_DONE;
  end

  // Handshake outputs, decoded from the state register
  always_comb begin
    bus.out_ready     = 1'b0;
    bus.out_res_valid = 1'b0;
    case (state_q)
      S_IDLE: bus.out_ready = 1'b1;
      S_DONE: begin
        bus.out_res_valid = 1'b1;
`ifdef FP_SEQ_B2B_EN
        bus.out_ready     = bus.in_res_ready;
`endif
      end
      default: ;
    endcase
  end

  // Datapath next values: latch on accept, count down in EXEC, capture on the last cycle
  always_comb begin
    cnt_d     = cnt_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    op_d      = op_q;
    fmt_d     = fmt_q;
    ofmt_d    = ofmt_q;
    addsub_d  = addsub_q;
    ctrl_d    = ctrl_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    if (state_q == S_EXEC && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    if (capture) begin
      result_d  = bus.in_fpu_result;
      illegal_d = 1'b0;
    end
    if (accept) begin
      rs1_d    = bus.in_rs1;
      rs2_d    = bus.in_rs2;
      op_d     = bus.in_FPU_Op;
      fmt_d    = bus.in_fmt;
      ofmt_d   = bus.in_output_fmt;
      addsub_d = bus.in_addsub_ctrl;
      ctrl_d   = bus.in_ctrl_minmax_sgnj_cmp;
      if (op_legal) begin
        cnt_d = lat_m1(bus.in_FPU_Op);
      end else begin
        result_d  = '0;
        illegal_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cnt_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      op_q      <= '0;
      fmt_q     <= 1'b0;
      ofmt_q    <= 1'b0;
      addsub_q  <= 1'b0;
      ctrl_q    <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      op_q      <= op_d;
      fmt_q     <= fmt_d;
      ofmt_q    <= ofmt_d;
      addsub_q  <= addsub_d;
      ctrl_q    <= ctrl_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.out_fpu_rs1        = rs1_q;
  assign bus.out_fpu_rs2        = rs2_q;
  assign bus.out_fpu_op         = op_q;
  assign bus.out_fpu_fmt        = fmt_q;
  assign bus.out_fpu_output_fmt = ofmt_q;
  assign bus.out_fpu_addsub     = addsub_q;
  assign bus.out_fpu_ctrl       = ctrl_q;
  assign bus.out_result         = result_q;
  assign bus.out_illegal        = illegal_q;

endmodule

// File: tb/tb_fp_unit_seq.sv
// Directed bench for fp_unit_seq. Every expected value is hand-computed.
module tb_fp_unit_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fp_unit_seq_if #(.DATA_WIDTH(64)) bus ();

  fp_unit_seq #(.DATA_WIDTH(64)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request while IDLE, then return just after the accept edge
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] ctrl);
    bus.in_valid                = 1'b1;
    bus.in_FPU_Op               = op;
    bus.in_rs1                  = a;
    bus.in_rs2                  = b;
    bus.in_ctrl_minmax_sgnj_cmp = ctrl;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_res_valid is high. The wait is bounded, and 0 means it never rose.
  task automatic wait_valid(output int edges);
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.out_res_valid) begin
        edges = i;
        break;
      end
    end
  endtask

  int edges;
  int acc [3];
  int n_acc;
  int exp_gap;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n                       = 1'b0;
    bus.in_valid                = 1'b0;
    bus.in_rs1                  = '0;
    bus.in_rs2                  = '0;
    bus.in_FPU_Op               = '0;
    bus.in_fmt                  = 1'b0;
    bus.in_output_fmt           = 1'b0;
    bus.in_addsub_ctrl          = 1'b0;
    bus.in_ctrl_minmax_sgnj_cmp = '0;
    bus.in_abort                = 1'b0;
    bus.in_fpu_result           = '0;
    bus.in_res_ready            = 1'b0;

    // Reset state
    tick();
    check("rst_ready", 64'(bus.out_ready), 64'd1);
    check("rst_valid", 64'(bus.out_res_valid), 64'd0);
    check("rst_illegal", 64'(bus.out_illegal), 64'd0);
    check("rst_result", bus.out_result, 64'd0);
    check("rst_fpu_rs1", bus.out_fpu_rs1, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // DIV: the result rises 8 edges after accept, and the operands hold throughout
    bus.in_fpu_result = 64'h4000_0000_0000_0000;
    bus.in_fmt        = 1'b1;
    issue(4'b0010, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 3'b101);
    bus.in_fmt = 1'b0;
    bus.in_rs1 = 64'hFFFF_0000_FFFF_0000;
    check("div_op", 64'(bus.out_fpu_op), 64'd2);
    check("div_rs2", bus.out_fpu_rs2, 64'h5555_6666_7777_8888);
    check("div_fmt", 64'(bus.out_fpu_fmt), 64'd1);
    check("div_ctrl", 64'(bus.out_fpu_ctrl), 64'd5);
    check("div_busy_ready", 64'(bus.out_ready), 64'd0);
    wait_valid(edges);
    check("div_latency", 64'(edges), 64'd8);
    check("div_rs1_hold", bus.out_fpu_rs1, 64'h1111_2222_3333_4444);
    check("div_result", bus.out_result, 64'h4000_0000_0000_0000);
    check("div_illegal", 64'(bus.out_illegal), 64'd0);

    // Backpressure: the result and out_ready hold while the consumer stalls
    for (int i = 0; i < 5; i++) begin
      bus.in_fpu_result = ~bus.in_fpu_result;
      tick();
      check("bp_result", bus.out_result, 64'h4000_0000_0000_0000);
      check("bp_ready", 64'(bus.out_ready), 64'd0);
      check("bp_valid", 64'(bus.out_res_valid), 64'd1);
    end
    bus.in_res_ready = 1'b1;
    tick();
    bus.in_res_ready = 1'b0;
    check("retire_valid", 64'(bus.out_res_valid), 64'd0);
    check("retire_ready", 64'(bus.out_ready), 64'd1);

    // Illegal op: the accept edge goes straight to DONE with a zero result
    issue(4'b1010, 64'hAA, 64'hBB, 3'b000);
    check("ill_valid", 64'(bus.out_res_valid), 64'd1);
    check("ill_result", bus.out_result, 64'd0);
    check("ill_flag", 64'(bus.out_illegal), 64'd1);
    bus.in_res_ready = 1'b1;
    tick();
    bus.in_res_ready = 1'b0;

    // Abort on the cnt==0 cycle of ADDSUB beats the capture
    bus.in_fpu_result  = 64'h0000_DEAD_BEEF_0000;
    bus.in_addsub_ctrl = 1'b1;
    issue(4'b0000, 64'h1, 64'h2, 3'b000);
    check("abort_addsub", 64'(bus.out_fpu_addsub), 64'd1);
    tick();
    bus.in_abort = 1'b1;
    tick();
    bus.in_abort = 1'b0;
    check("abort_ready", 64'(bus.out_ready), 64'd1);
    check("abort_valid", 64'(bus.out_res_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_res", 64'(bus.out_res_valid), 64'd0);
    end
    check("abort_result_kept", bus.out_result, 64'd0);

    // Reset in the middle of MUL discards the op
    issue(4'b0001, 64'h3, 64'h4, 3'b000);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(bus.out_res_valid), 64'd0);
    check("rst_mid_ready", 64'(bus.out_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_mid_no_res", 64'(bus.out_res_valid), 64'd0);
    end

    // MUL end to end: 3-edge latency and the result is captured
    bus.in_fpu_result = 64'h3FF0_0000_0000_0000;
    issue(4'b0001, 64'h7, 64'h8, 3'b010);
    wait_valid(edges);
    check("mul_latency", 64'(edges), 64'd3);
    check("mul_result", bus.out_result, 64'h3FF0_0000_0000_0000);
    bus.in_res_ready = 1'b1;
    tick();
    bus.in_res_ready = 1'b0;

    // Issue interval with in_valid held and the consumer always ready (MISC op)
    bus.in_FPU_Op    = 4'b0011;
    bus.in_valid     = 1'b1;
    bus.in_res_ready = 1'b1;
    n_acc = 0;
    acc   = '{default: 0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_ready && n_acc < 3) begin
        acc[n_acc] = k;
        n_acc++;
      end
    end
`ifdef FP_SEQ_B2B_EN
    exp_gap = 2;
`else
    exp_gap = 3;
`endif
    check("b2b_gap0", 64'(acc[1] - acc[0]), 64'(exp_gap));
    check("b2b_gap1", 64'(acc[2] - acc[1]), 64'(exp_gap));
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("drain_ready", 64'(bus.out_ready), 64'd1);
    bus.in_res_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
